// File: rtl/alu_arbiter_2ch.sv
// alu_arbiter_2ch
// Two requesters share one W-bit ALU. A round-robin arbiter grants one
// request at a time. A three-state FSM (IDLE -> EXEC -> RESP) runs the
// single operation in flight and returns its result to the owning channel.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  [1:0]    per-channel request valid
//   req_ready  [1:0]    per-channel request accept (combinational, IDLE only)
//   req_a      [2*W-1:0] operand A, channel i at [i*W +: W]
//   req_b      [2*W-1:0] operand B, same packing
//   req_sel    [5:0]    opcode, channel i at [i*3 +: 3]
//   rsp_valid  [1:0]    per-channel result valid
//   rsp_ready  [1:0]    per-channel result consume
//   rsp_y      [W-1:0]  shared result
//   rsp_c               shared carry/borrow flag
//   busy                high while an operation is in EXEC or RESP
module alu_arbiter_2ch #(
  parameter int W         = 8,
  parameter bit CH0_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [5:0]     req_sel,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W-1:0]   rsp_y,
  output logic           rsp_c,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic           ptr_r;        // channel that wins the next tie
  logic           owner_r;      // channel that owns the in-flight operation
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [2:0]     sel_r;
  logic [W-1:0]   rsp_y_r;
  logic           rsp_c_r;
  logic [1:0]     rsp_valid_r;
  logic           busy_r;
  logic [1:0]     grant_s;
  logic [W:0]     alu_res_s;

  // ALU result packed as {carry, y}; carry is only meaningful for add/sub.
  function automatic logic [W:0] alu_fn(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [2:0]   sel);
    logic [W:0] sum;
    logic [W:0] res;
    sum = {1'b0, a} + {1'b0, b};
    case (sel)
      3'b000:  res = sum;
      3'b001:  res = {(a < b), a - b};
      3'b010:  res = {1'b0, a & b};
      3'b011:  res = {1'b0, a | b};
      3'b100:  res = {1'b0, a ^ b};
      3'b101:  res = {1'b0, ~a};
      3'b110:  res = {1'b0, a[W-2:0], 1'b0};
      3'b111:  res = {1'b0, 1'b0, a[W-1:1]};
      default: res = {(W+1){1'b0}};
    endcase
    return res;
  endfunction

  // Round-robin grant: a lone valid channel wins; on a tie the pointer decides.
  always_comb begin
    grant_s = 2'b00;
    if (state_r == ST_IDLE) begin
      case (req_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = ptr_r ? 2'b10 : 2'b01;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  assign req_ready = grant_s;
  assign alu_res_s = alu_fn(a_r, b_r, sel_r);

  // Next-state logic for the IDLE/EXEC/RESP sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s != 2'b00) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready[owner_r]) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, captured operands, registered result and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= CH0_FIRST ? 1'b0 : 1'b1;
      owner_r     <= 1'b0;
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      sel_r       <= 3'b000;
      rsp_y_r     <= {W{1'b0}};
      rsp_c_r     <= 1'b0;
      rsp_valid_r <= 2'b00;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (grant_s != 2'b00) begin
            // grant_s is one-hot here, so bit 1 names the winning channel.
            owner_r <= grant_s[1];
            a_r     <= grant_s[1] ? req_a[2*W-1:W] : req_a[W-1:0];
            b_r     <= grant_s[1] ? req_b[2*W-1:W] : req_b[W-1:0];
            sel_r   <= grant_s[1] ? req_sel[5:3]   : req_sel[2:0];
            busy_r  <= 1'b1;
          end
        end
        ST_EXEC: begin
          rsp_c_r     <= alu_res_s[W];
          rsp_y_r     <= alu_res_s[W-1:0];
          rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
        end
        ST_RESP: begin
          if (rsp_ready[owner_r]) begin
            rsp_valid_r <= 2'b00;
            ptr_r       <= ~owner_r;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          rsp_valid_r <= 2'b00;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_y     = rsp_y_r;
  assign rsp_c     = rsp_c_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_alu_arbiter_2ch.sv
module tb_alu_arbiter_2ch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [15:0] req_a = 16'h0000;
  logic [15:0] req_b = 16'h0000;
  logic [5:0]  req_sel = 6'b000000;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [7:0]  rsp_y;
  logic        rsp_c;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_arbiter_2ch #(.W(8), .CH0_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_c(rsp_c), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request on one channel and hold it until accepted (bounded).
  // Returns one cycle after the accepting edge, i.e. in the EXEC cycle.
  task automatic issue(input int ch, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sel, output bit ok);
    ok = 1'b0;
    req_a[ch*8 +: 8]  = a;
    req_b[ch*8 +: 8]  = b;
    req_sel[ch*3 +: 3] = sel;
    req_valid[ch] = 1'b1;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (req_ready[ch] === 1'b1) ok = 1'b1;
      step();
    end
    req_valid[ch] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b01;
    step();
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
    tests++; if (rsp_y !== 8'h00) begin fails++; $display("FAIL reset_rsp_y got %h want 00", rsp_y); end
    tests++; if (rsp_c !== 1'b0) begin fails++; $display("FAIL reset_rsp_c got %b want 0", rsp_c); end
    req_valid = 2'b00;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ch0_add();
    bit ok;
    issue(0, 8'h0F, 8'h01, 3'b000, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL ch0_accept got timeout want accept"); end
    tests++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin fails++; $display("FAIL ch0_exec got valid=%b busy=%b want 00/1", rsp_valid, busy); end
    step();
    tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL ch0_rsp_valid got %b want 01", rsp_valid); end
    tests++; if (rsp_y !== 8'h10 || rsp_c !== 1'b0) begin fails++; $display("FAIL ch0_add got y=%h c=%b want 10/0", rsp_y, rsp_c); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL ch0_done got valid=%b busy=%b want 00/0", rsp_valid, busy); end
  endtask

  task automatic test_ch1();
    logic [7:0] va [3] = '{8'h80, 8'hFF, 8'h00};
    logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h01};
    logic [2:0] vs [3] = '{3'b001, 3'b000, 3'b001};
    logic [7:0] ey [3] = '{8'h7F, 8'h00, 8'hFF};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};
    bit ok;
    for (int k = 0; k < 3; k++) begin
      issue(1, va[k], vb[k], vs[k], ok);
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL ch1_accept[%0d] got timeout want accept", k); end
      step();
      tests++; if (rsp_valid !== 2'b10) begin fails++; $display("FAIL ch1_rsp_valid[%0d] got %b want 10", k, rsp_valid); end
      tests++; if (rsp_y !== ey[k] || rsp_c !== ec[k]) begin fails++; $display("FAIL ch1_result[%0d] got y=%h c=%b want %h/%b", k, rsp_y, rsp_c, ey[k], ec[k]); end
      rsp_ready = 2'b10;
      step();
      rsp_ready = 2'b00;
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_oh;
    req_a = {8'hAA, 8'hF0};
    req_b = {8'h55, 8'h0F};
    req_sel = {3'b011, 3'b010};
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      tests++; if (req_ready !== exp_oh) begin fails++; $display("FAIL fair_grant[%0d] got %b want %b", k, req_ready, exp_oh); end
      step();
      step();
      tests++; if (rsp_valid !== exp_oh) begin fails++; $display("FAIL fair_owner[%0d] got %b want %b", k, rsp_valid, exp_oh); end
      if (k % 2 == 0) begin
        tests++; if (rsp_y !== 8'h00 || rsp_c !== 1'b0) begin fails++; $display("FAIL fair_and[%0d] got y=%h c=%b want 00/0", k, rsp_y, rsp_c); end
      end else begin
        tests++; if (rsp_y !== 8'hFF || rsp_c !== 1'b0) begin fails++; $display("FAIL fair_or[%0d] got y=%h c=%b want FF/0", k, rsp_y, rsp_c); end
      end
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
  endtask

  task automatic test_back_pressure();
    bit ok;
    issue(0, 8'h0F, 8'h00, 3'b110, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL bp_accept got timeout want accept"); end
    req_a[15:8] = 8'h01; req_b[15:8] = 8'h02; req_sel[5:3] = 3'b000;
    req_valid = 2'b10;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_exec_ready got %b want 00", req_ready); end
    step();
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (rsp_valid !== 2'b01 || rsp_y !== 8'h1E || rsp_c !== 1'b0 || busy !== 1'b1 || req_ready !== 2'b00) begin
        fails++;
        $display("FAIL bp_hold[%0d] got valid=%b y=%h c=%b busy=%b ready=%b want 01/1E/0/1/00",
                 k, rsp_valid, rsp_y, rsp_c, busy, req_ready);
      end
      step();
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL bp_release got %b want 00", rsp_valid); end
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_ch1_grant got %b want 10", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    tests++; if (rsp_valid !== 2'b10 || rsp_y !== 8'h03) begin fails++; $display("FAIL bp_ch1_result got valid=%b y=%h want 10/03", rsp_valid, rsp_y); end
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
  endtask

  task automatic test_operand_change();
    logic [7:0] va [3] = '{8'hCC, 8'hFF, 8'hF0};
    logic [7:0] vb [3] = '{8'h33, 8'h00, 8'h00};
    logic [2:0] vs [3] = '{3'b100, 3'b101, 3'b111};
    logic [7:0] ey [3] = '{8'hFF, 8'h00, 8'h78};
    bit ok;
    for (int k = 0; k < 3; k++) begin
      issue(0, va[k], vb[k], vs[k], ok);
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL opchg_accept[%0d] got timeout want accept", k); end
      req_a[7:0] = 8'h00; req_b[7:0] = 8'h00; req_sel[2:0] = 3'b000;
      step();
      tests++; if (rsp_valid !== 2'b01 || rsp_y !== ey[k] || rsp_c !== 1'b0) begin fails++; $display("FAIL opchg_result[%0d] got valid=%b y=%h c=%b want 01/%h/0", k, rsp_valid, rsp_y, rsp_c, ey[k]); end
      rsp_ready = 2'b01;
      step();
      rsp_ready = 2'b00;
    end
  endtask

  task automatic test_rst_exec();
    bit ok;
    // Previous owner was ch0, so without reset the pointer would favour ch1.
    issue(0, 8'h12, 8'h34, 3'b000, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rst_accept got timeout want accept"); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_y !== 8'h00 || rsp_c !== 1'b0) begin fails++; $display("FAIL rst_exec_outputs got valid=%b busy=%b y=%h c=%b want 00/0/00/0", rsp_valid, busy, rsp_y, rsp_c); end
    req_a = {8'h09, 8'h03}; req_b = {8'h01, 8'h01}; req_sel = {3'b000, 3'b001};
    req_valid = 2'b11;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL rst_first_grant got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL rst_no_pulse got %b want 00", rsp_valid); end
    step();
    tests++; if (rsp_valid !== 2'b01 || rsp_y !== 8'h02 || rsp_c !== 1'b0) begin fails++; $display("FAIL rst_after_result got valid=%b y=%h c=%b want 01/02/0", rsp_valid, rsp_y, rsp_c); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
  endtask

  initial begin
    #1;
    test_reset();
    test_ch0_add();
    test_ch1();
    test_fairness();
    test_back_pressure();
    test_operand_change();
    test_rst_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
